// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file context save/restore engine:
// the engine state encoding, register index width, default word width and
// the index of the hard-wired zero register.
// No ports (package).

package regfile_pkg;

  localparam int REG_IDX_W          = 5;
  localparam int DATA_WIDTH_DEFAULT = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // CHK is only reachable when the checksum feature is compiled in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAP  = 3'd2,
    SEND    = 3'd3,
    LOAD    = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6,
    CHK     = 3'd7
  } ctx_state_t;

endpackage

// File: rtl/ctx_xor_acc.sv
// ctx_xor_acc
// Running XOR accumulator used for the context checksum word.
// Only compiled when CTX_CHECKSUM_EN is defined; the default build has no
// checksum logic at all.
// Ports:
//   clock       rising-edge clock
//   ctrl_reset  asynchronous active-low reset (clears the accumulator)
//   clear       synchronous clear, wins over enable
//   enable      fold data into the accumulator this cycle
//   data        word to fold in
//   acc         current accumulator value

`ifdef CTX_CHECKSUM_EN
module ctx_xor_acc
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] acc
);

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc ^ data;
    end
  end

endmodule
`endif

// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine
// Context save/restore initiator for the 32x32 register file. In save mode it
// sweeps FIRST_REG..LAST_REG through read port A and streams the words out on
// the dump channel; in restore mode it takes words from the load channel and
// writes them into FIRST_REG..LAST_REG through the write port.
// Optional feature macro: CTX_CHECKSUM_EN (running XOR checksum word appended
// to a save, checked as an extra word on restore, mismatch flagged on ckerr).
// Ports:
//   clock, ctrl_reset           clock and asynchronous active-low reset
//   start, mode, abort          control (mode 0 = save, 1 = restore)
//   busy, done                  status (done is a one-cycle pulse)
//   ckerr                       checksum mismatch flag (CTX_CHECKSUM_EN only)
//   rf_writeEn/Reg/Data         regfile write port
//   rf_readReg, rf_readData     regfile read port A (combinational read)
//   dump_data/valid/ready       save stream (engine is the source)
//   load_data/valid/ready       restore stream (engine is the sink)

module regfile_ctx_engine
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
`ifdef CTX_CHECKSUM_EN
  output logic                  ckerr,
`endif
  output logic                  rf_writeEn,
  output logic [REG_IDX_W-1:0]  rf_writeReg,
  output logic [DATA_WIDTH-1:0] rf_writeData,
  output logic [REG_IDX_W-1:0]  rf_readReg,
  input  logic [DATA_WIDTH-1:0] rf_readData,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready
);

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

  ctx_state_t state, state_next;
  logic [REG_IDX_W-1:0] index, index_next;

  logic                  busy_d, done_d, dump_valid_d, load_ready_d, rf_writeEn_d;
  logic [REG_IDX_W-1:0]  rf_writeReg_d, rf_readReg_d;
  logic [DATA_WIDTH-1:0] rf_writeData_d, dump_data_d;

  logic kill, dump_fire, load_fire, at_last;

  // abort outranks every handshake, so the fire terms are masked by it.
  assign kill      = (state != IDLE) && abort;
  assign dump_fire = (state == SEND) && dump_valid && dump_ready && !abort;
  assign load_fire = (state == LOAD) && load_valid && load_ready && !abort;
  assign at_last   = (index == LAST_IDX);

`ifdef CTX_CHECKSUM_EN
  logic                  ck_phase, ck_phase_d;
  logic                  ckerr_d;
  logic                  chk_fire, ck_clear, ck_enable;
  logic [DATA_WIDTH-1:0] ck_data, xor_acc;

  // Save folds words in as they are captured, restore as they are accepted,
  // so by the end of the sweep the accumulator covers all swept registers.
  assign chk_fire  = (state == CHK) && load_valid && load_ready && !abort;
  assign ck_clear  = (state == IDLE) && start;
  assign ck_enable = ((state == RD_CAP) && !abort) || load_fire;
  assign ck_data   = (state == RD_CAP) ? rf_readData : load_data;

  ctx_xor_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_xor_acc (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .clear      (ck_clear),
    .enable     (ck_enable),
    .data       (ck_data),
    .acc        (xor_acc)
  );
`endif

  // State, index and every output are registered here; the two comb blocks
  // below compute their next values.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state        <= IDLE;
      index        <= FIRST_IDX;
      busy         <= 1'b0;
      done         <= 1'b0;
      rf_writeEn   <= 1'b0;
      rf_writeReg  <= '0;
      rf_writeData <= '0;
      rf_readReg   <= '0;
      dump_data    <= '0;
      dump_valid   <= 1'b0;
      load_ready   <= 1'b0;
`ifdef CTX_CHECKSUM_EN
      ck_phase     <= 1'b0;
      ckerr        <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      index        <= index_next;
      busy         <= busy_d;
      done         <= done_d;
      rf_writeEn   <= rf_writeEn_d;
      rf_writeReg  <= rf_writeReg_d;
      rf_writeData <= rf_writeData_d;
      rf_readReg   <= rf_readReg_d;
      dump_data    <= dump_data_d;
      dump_valid   <= dump_valid_d;
      load_ready   <= load_ready_d;
`ifdef CTX_CHECKSUM_EN
      ck_phase     <= ck_phase_d;
      ckerr        <= ckerr_d;
`endif
    end
  end

  // Sweep sequencing. The index only advances after a completed transfer
  // and stops at LAST_REG, so it never wraps.
  always_comb begin
    state_next = state;
    index_next = index;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = mode ? LOAD : RD_ADDR;
          index_next = FIRST_IDX;
        end
      end
      RD_ADDR: state_next = RD_CAP;
      RD_CAP:  state_next = SEND;
      SEND: begin
        if (dump_fire) begin
`ifdef CTX_CHECKSUM_EN
          // After the last register the checksum word goes out through SEND.
          if (ck_phase) begin
            state_next = DONE;
          end else if (at_last) begin
            state_next = SEND;
          end else begin
            state_next = RD_ADDR;
            index_next = index + 5'd1;
          end
`else
          if (at_last) begin
            state_next = DONE;
          end else begin
            state_next = RD_ADDR;
            index_next = index + 5'd1;
          end
`endif
        end
      end
      LOAD: begin
        if (load_fire) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (at_last) begin
`ifdef CTX_CHECKSUM_EN
          state_next = CHK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = LOAD;
          index_next = index + 5'd1;
        end
      end
`ifdef CTX_CHECKSUM_EN
      CHK: begin
        if (chk_fire) begin
          state_next = DONE;
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) begin
      state_next = IDLE;
      index_next = index;
    end
  end

  // Output next values. Status and handshake outputs follow the next state,
  // so an abort drops them on the very edge that returns to IDLE. The data
  // and index outputs hold between updates.
  always_comb begin
    busy_d         = (state_next != IDLE);
    done_d         = (state_next == DONE);
    dump_valid_d   = (state_next == SEND);
    load_ready_d   = (state_next == LOAD);
    rf_writeEn_d   = (state == LOAD) && (state_next == WRITE) && (index != REG_ZERO);
    rf_writeReg_d  = rf_writeReg;
    rf_writeData_d = rf_writeData;
    rf_readReg_d   = rf_readReg;
    dump_data_d    = dump_data;

    if (rf_writeEn_d) begin
      rf_writeReg_d  = index;
      rf_writeData_d = load_data;
    end

    // rf_readReg stays on the index through RD_CAP so the capture sees it.
    if (state_next == RD_ADDR) begin
      rf_readReg_d = index_next;
    end

    if ((state == RD_CAP) && (state_next == SEND)) begin
      dump_data_d = rf_readData;
    end

`ifdef CTX_CHECKSUM_EN
    load_ready_d = (state_next == LOAD) || (state_next == CHK);
    ck_phase_d   = (state_next == SEND) && (ck_phase || ((state == SEND) && dump_fire));
    ckerr_d      = ckerr;
    if ((state == SEND) && dump_fire && (state_next == SEND)) begin
      dump_data_d = xor_acc;
    end
    if ((state == IDLE) && start) begin
      ckerr_d = 1'b0;
    end else if (chk_fire && (load_data != xor_acc)) begin
      ckerr_d = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// tb_regfile_ctx_engine
// Self-checking bench for regfile_ctx_engine. A behavioural 32x32 register
// file answers the read port and commits writes; expected stream words and
// expected regfile writes are queued when stimulus is issued and compared as
// the engine produces them. Build with CTX_CHECKSUM_EN to cover the
// checksum word and ckerr.

`timescale 1ns/1ps

module tb_regfile_ctx_engine;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        start, mode, abort;
  logic        busy, done;
  logic        rf_writeEn;
  logic [4:0]  rf_writeReg, rf_readReg;
  logic [31:0] rf_writeData, rf_readData;
  logic [31:0] dump_data, load_data;
  logic        dump_valid, dump_ready, load_valid, load_ready;
`ifdef CTX_CHECKSUM_EN
  logic        ckerr;
`endif

  logic [31:0] regs [32];
  logic        preload_en, preload_sel;

  int check_count = 0;
  int fail_count  = 0;
  int done_count  = 0;
  int wr_pulses   = 0;
  int wr_rises    = 0;
  int words_popped = 0;
  logic done_prev = 1'b0;
  logic wr_prev   = 1'b0;

  logic [31:0] dump_q [$];
  wr_t         wr_q [$];
  logic [31:0] exp_word;
  wr_t         exp_wr;

  always #5 clock = ~clock;

  assign rf_readData = regs[rf_readReg];

  regfile_ctx_engine #(
    .DATA_WIDTH (32),
    .FIRST_REG  (1),
    .LAST_REG   (31)
  ) dut (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .start        (start),
    .mode         (mode),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
`ifdef CTX_CHECKSUM_EN
    .ckerr        (ckerr),
`endif
    .rf_writeEn   (rf_writeEn),
    .rf_writeReg  (rf_writeReg),
    .rf_writeData (rf_writeData),
    .rf_readReg   (rf_readReg),
    .rf_readData  (rf_readData),
    .dump_data    (dump_data),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready)
  );

  // Regfile model: bulk preload for test setup, otherwise engine writes.
  always @(posedge clock) begin
    if (preload_en) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 0) ? 32'd0 : ((preload_sel ? 32'hA5A5_0000 : 32'h1000_0000) + 32'(i));
      end
    end else if (rf_writeEn) begin
      regs[rf_writeReg] <= rf_writeData;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor sampled on the falling edge: stream handshakes and write pulses
  // are popped against the scoreboard queues, done pulses are counted.
  always @(negedge clock) begin
    if (ctrl_reset) begin
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) begin
          checkOutput("dump_unexpected", 64'(dump_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_word = dump_q.pop_front();
          checkOutput("dump_word", 64'(dump_data), 64'(exp_word));
        end
        words_popped++;
      end
      if (rf_writeEn) begin
        wr_pulses++;
        if (!wr_prev) wr_rises++;
        checkOutput("wr_reg_nonzero", 64'(rf_writeReg == 5'd0), 64'd0);
        if (wr_q.size() == 0) begin
          checkOutput("wr_unexpected", 64'(rf_writeReg), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_wr = wr_q.pop_front();
          checkOutput("wr_idx", 64'(rf_writeReg), 64'(exp_wr.idx));
          checkOutput("wr_data", 64'(rf_writeData), 64'(exp_wr.data));
        end
      end
      if (done) done_count++;
      if (done_prev) checkOutput("busy_after_done", 64'(busy), 64'd0);
    end
    done_prev = done;
    wr_prev   = rf_writeEn;
  end

  task automatic applyStimulus(input logic m);
    @(posedge clock); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clock); #1;
    start = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic preload(input logic sel);
    @(posedge clock); #1;
    preload_sel = sel;
    preload_en  = 1'b1;
    @(posedge clock); #1;
    preload_en  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 2000);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic push_save_expect();
    logic [31:0] x = 32'd0;
    for (int i = 1; i <= 31; i++) begin
      dump_q.push_back(32'h1000_0000 + 32'(i));
      x = x ^ (32'h1000_0000 + 32'(i));
    end
`ifdef CTX_CHECKSUM_EN
    dump_q.push_back(x);
`endif
  endtask

  task automatic send_load_word(input logic [31:0] data, input logic [4:0] idx, input bit is_reg);
    int n = 0;
    repeat (2) @(posedge clock);
    #1;
    load_valid = 1'b1;
    load_data  = data;
    if (is_reg) wr_q.push_back('{idx: idx, data: data});
    do begin
      @(negedge clock);
      n++;
    end while (!load_ready && n < 100);
    checkOutput("load_hs_ready", 64'(load_ready), 64'd1);
    @(posedge clock); #1;
    load_valid = 1'b0;
    load_data  = 32'd0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    fail_count++;
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, w0, r0, n;
    ctrl_reset  = 1'b0;
    start       = 1'b0;
    mode        = 1'b0;
    abort       = 1'b0;
    dump_ready  = 1'b0;
    load_valid  = 1'b0;
    load_data   = 32'd0;
    preload_en  = 1'b0;
    preload_sel = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_handshakes", 64'({dump_valid, load_ready, rf_writeEn}), 64'd0);
    checkOutput("rst_read_idx", 64'(rf_readReg), 64'd0);
    preload(1'b0);
    ctrl_reset = 1'b1;

    // Save sweep with a second start pulsed mid-operation
    $display("[TB] save sweep with ignored second start");
    dump_ready = 1'b1;
    push_save_expect();
    d0 = done_count;
    applyStimulus(1'b0);
    repeat (20) @(posedge clock);
    #1;
    start = 1'b1;
    mode  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    mode  = 1'b0;
    wait_idle("save1");
    checkOutput("save1_done_once", 64'(done_count - d0), 64'd1);
    checkOutput("save1_all_words", 64'(dump_q.size()), 64'd0);
    checkOutput("save1_no_writes", 64'(wr_pulses), 64'd0);
    repeat (3) @(negedge clock);
    checkOutput("save1_stays_idle", 64'(busy), 64'd0);

    // Save with back-pressure on word 3
    $display("[TB] save with dump_ready stalled on word 3");
    push_save_expect();
    d0 = done_count;
    w0 = words_popped;
    applyStimulus(1'b0);
    n = 0;
    while ((words_popped - w0) < 2 && n < 200) begin
      @(posedge clock);
      n++;
    end
    #1;
    dump_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dump_valid && n < 20);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      checkOutput("stall_valid", 64'(dump_valid), 64'd1);
      checkOutput("stall_data", 64'(dump_data), 64'h1000_0003);
    end
    @(posedge clock); #1;
    dump_ready = 1'b1;
    wait_idle("save2");
    checkOutput("save2_done_once", 64'(done_count - d0), 64'd1);
    checkOutput("save2_all_words", 64'(dump_q.size()), 64'd0);

    // Restore sweep with 2-cycle gaps between words
    $display("[TB] restore sweep");
    preload(1'b1);
    d0 = done_count;
    w0 = wr_pulses;
    r0 = wr_rises;
    applyStimulus(1'b1);
    for (int i = 1; i <= 31; i++) begin
      send_load_word(32'hDEAD_0000 + 32'(i), 5'(i), 1'b1);
    end
`ifdef CTX_CHECKSUM_EN
    send_load_word(32'h0000_0001, 5'd0, 1'b0);
`endif
    wait_idle("restore1");
    checkOutput("restore1_done_once", 64'(done_count - d0), 64'd1);
    checkOutput("restore1_wr_cycles", 64'(wr_pulses - w0), 64'd31);
    checkOutput("restore1_wr_pulses", 64'(wr_rises - r0), 64'd31);
    checkOutput("restore1_wr_queue", 64'(wr_q.size()), 64'd0);
    for (int i = 1; i <= 31; i++) begin
      checkOutput("restore1_reg", 64'(regs[i]), 64'(32'hDEAD_0000 + 32'(i)));
    end
    checkOutput("restore1_reg0", 64'(regs[0]), 64'd0);
`ifdef CTX_CHECKSUM_EN
    checkOutput("restore1_ckerr", 64'(ckerr), 64'd1);
`endif

    // Restore aborted while word 10 is being written
    $display("[TB] restore aborted at word 10");
    preload(1'b1);
    d0 = done_count;
    applyStimulus(1'b1);
    for (int i = 1; i <= 10; i++) begin
      send_load_word(32'hDEAD_0000 + 32'(i), 5'(i), 1'b1);
    end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_outputs", 64'({load_ready, rf_writeEn, dump_valid}), 64'd0);
    repeat (5) @(negedge clock);
    checkOutput("abort_no_done", 64'(done_count - d0), 64'd0);
    checkOutput("abort_wr_queue", 64'(wr_q.size()), 64'd0);
    for (int i = 1; i <= 31; i++) begin
      checkOutput("abort_reg", 64'(regs[i]),
                  (i <= 10) ? 64'(32'hDEAD_0000 + 32'(i)) : 64'(32'hA5A5_0000 + 32'(i)));
    end

    // Asynchronous reset in the middle of a save
    $display("[TB] reset mid-save");
    preload(1'b0);
    push_save_expect();
    applyStimulus(1'b0);
    repeat (15) @(posedge clock);
    #3;
    ctrl_reset = 1'b0;
    #1;
    checkOutput("arst_ctrl", 64'({busy, done, dump_valid, load_ready, rf_writeEn}), 64'd0);
    checkOutput("arst_dump_data", 64'(dump_data), 64'd0);
    checkOutput("arst_rf_ports", 64'({rf_readReg, rf_writeReg, rf_writeData}), 64'd0);
    dump_q.delete();
    @(posedge clock); #1;
    ctrl_reset = 1'b1;
    push_save_expect();
    d0 = done_count;
    applyStimulus(1'b0);
    wait_idle("save3");
    checkOutput("save3_done_once", 64'(done_count - d0), 64'd1);
    checkOutput("save3_all_words", 64'(dump_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
